// File: rtl/solver_pkg.sv
// rtl/solver_pkg.sv - shared types and constants for the swap scheduler
// Contents: point_t (x,y pair), state_t (scheduler FSM states),
// window slot indices for the six-point check window.
package solver_pkg;

  localparam int PT_CW = 8;

  typedef struct packed {
    logic [PT_CW-1:0] x;
    logic [PT_CW-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SWAP,
    S_NEXT,
    S_DONE
  } state_t;

  // Slot k of the window occupies bits [k*CW +: CW] of chk_xs/chk_ys.
  localparam int SLOT_IM1 = 0;
  localparam int SLOT_I   = 1;
  localparam int SLOT_IP1 = 2;
  localparam int SLOT_JM1 = 3;
  localparam int SLOT_J   = 4;
  localparam int SLOT_JP1 = 5;
  localparam int NSLOT    = 6;

endpackage

// File: rtl/swap_scheduler_if.sv
// rtl/swap_scheduler_if.sv - scheduler to swap-checker handshake
// Signals: chk_start (issue pulse), chk_xs/chk_ys (six-point window),
// chk_res (verdict), chk_complete (verdict strobe).
// master = scheduler side, slave = checker side.
interface swap_scheduler_if
  import solver_pkg::*;
#(
  parameter int CW = 8
) ();

  logic                  chk_start;
  logic [NSLOT*CW-1:0]   chk_xs;
  logic [NSLOT*CW-1:0]   chk_ys;
  logic                  chk_res;
  logic                  chk_complete;

  modport master (
    output chk_start,
    output chk_xs,
    output chk_ys,
    input  chk_res,
    input  chk_complete
  );

  modport slave (
    input  chk_start,
    input  chk_xs,
    input  chk_ys,
    output chk_res,
    output chk_complete
  );

endinterface

// File: rtl/pair_iter.sv
// rtl/pair_iter.sv - non-adjacent node pair (i,j) iterator
// Ports: clk, rst (async active-low), i_init (restart at 1,3),
// i_adv (step to next pair), o_i/o_j (current pair),
// o_i_nxt/o_j_nxt (pair after this edge), o_last (current pair ends the pass).
module pair_iter #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init,
  input  logic          i_adv,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic [IW-1:0] o_i_nxt,
  output logic [IW-1:0] o_j_nxt,
  output logic          o_last
);

  localparam logic [IW-1:0] I_LAST = IW'(N - 4);
  localparam logic [IW-1:0] J_LAST = IW'(N - 2);

  logic [IW-1:0] r_i, r_j;
  logic [IW-1:0] w_i_nxt, w_j_nxt;

  // j sweeps up to N-2 so that j+1 stays inside the path; then i steps
  // and j restarts two past it to keep the pair non-adjacent.
  always_comb begin
    w_i_nxt = r_i;
    w_j_nxt = r_j;
    if (i_init) begin
      w_i_nxt = IW'(1);
      w_j_nxt = IW'(3);
    end else if (i_adv) begin
      if (r_j < J_LAST) begin
        w_j_nxt = r_j + IW'(1);
      end else begin
        w_i_nxt = r_i + IW'(1);
        w_j_nxt = r_i + IW'(3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= IW'(1);
      r_j <= IW'(3);
    end else begin
      r_i <= w_i_nxt;
      r_j <= w_j_nxt;
    end
  end

  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_i_nxt = w_i_nxt;
  assign o_j_nxt = w_j_nxt;
  assign o_last  = (r_i == I_LAST) && (r_j == J_LAST);

endmodule

// File: rtl/swap_scheduler.sv
// rtl/swap_scheduler.sv - swap-check initiator walking all non-adjacent pairs
// Ports: clk, rst (async active-low); i_ld_en/i_ld_idx/i_ld_x/i_ld_y point load;
// i_start run request; i_rd_idx/o_rd_x/o_rd_y combinational readback;
// o_busy, o_done, o_swap_count, o_err run status; chk = checker handshake.
module swap_scheduler
  import solver_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int CW         = 8,
  parameter  int MAX_PASSES = 16,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ld_en,
  input  logic [IW-1:0]   i_ld_idx,
  input  logic [CW-1:0]   i_ld_x,
  input  logic [CW-1:0]   i_ld_y,
  input  logic            i_start,
  input  logic [IW-1:0]   i_rd_idx,
  output logic [CW-1:0]   o_rd_x,
  output logic [CW-1:0]   o_rd_y,
  output logic            o_busy,
  output logic            o_done,
  output logic [15:0]     o_swap_count,
  output logic            o_err,
  swap_scheduler_if.master chk
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(MAX_PASSES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PASS_MAX = PW'(MAX_PASSES);

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pt_t;

  state_t              r_state, w_state_nxt;
  pt_t                 r_pts [N];
  logic [TW-1:0]       r_tmo;
  logic [PW-1:0]       r_pass;
  logic                r_pass_swapped;
  logic [15:0]         r_swap_count;
  logic                r_err;
  logic [NSLOT*CW-1:0] r_xs, r_ys;

  logic                w_busy, w_ld_we, w_go, w_tmo, w_new_pass;
  logic                w_it_init, w_it_adv, w_it_last;
  logic [IW-1:0]       w_i, w_j, w_i_nxt, w_j_nxt;
  logic [IW-1:0]       w_slot_idx [NSLOT];
  pt_t                 w_win [NSLOT];

  assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_ld_we = i_ld_en && !w_busy && (32'(i_ld_idx) < N);

  pair_iter #(.N(N)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_init  (w_it_init),
    .i_adv   (w_it_adv),
    .o_i     (w_i),
    .o_j     (w_j),
    .o_i_nxt (w_i_nxt),
    .o_j_nxt (w_j_nxt),
    .o_last  (w_it_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_tmo       = 1'b0;
    w_new_pass  = 1'b0;
    w_it_init   = 1'b0;
    w_it_adv    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (i_start) begin
          w_go        = 1'b1;
          w_it_init   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (chk.chk_complete) begin
          w_state_nxt = chk.chk_res ? S_SWAP : S_NEXT;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_NEXT;
        end
      end
      S_SWAP: w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (!w_it_last) begin
          w_it_adv    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (r_pass_swapped && (r_pass < PASS_MAX)) begin
          w_new_pass  = 1'b1;
          w_it_init   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_it_init   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window is captured on the edge entering ISSUE from the pair that will be
  // current then; a load landing on the same edge is forwarded so that a
  // start issued together with the last load sees the new point.
  always_comb begin
    w_slot_idx[SLOT_IM1] = w_i_nxt - IW'(1);
    w_slot_idx[SLOT_I]   = w_i_nxt;
    w_slot_idx[SLOT_IP1] = w_i_nxt + IW'(1);
    w_slot_idx[SLOT_JM1] = w_j_nxt - IW'(1);
    w_slot_idx[SLOT_J]   = w_j_nxt;
    w_slot_idx[SLOT_JP1] = w_j_nxt + IW'(1);
    for (int k = 0; k < NSLOT; k++) begin
      w_win[k] = r_pts[w_slot_idx[k]];
      if (w_ld_we && (i_ld_idx == w_slot_idx[k])) w_win[k] = {i_ld_x, i_ld_y};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) r_pts[k] <= '0;
    end else if (w_ld_we) begin
      r_pts[i_ld_idx] <= {i_ld_x, i_ld_y};
    end else if (r_state == S_SWAP) begin
      r_pts[w_i] <= r_pts[w_j];
      r_pts[w_j] <= r_pts[w_i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo          <= '0;
      r_pass         <= '0;
      r_pass_swapped <= 1'b0;
      r_swap_count   <= '0;
      r_err          <= 1'b0;
      r_xs           <= '0;
      r_ys           <= '0;
    end else begin
      if (r_state == S_ISSUE)     r_tmo <= '0;
      else if (r_state == S_WAIT) r_tmo <= r_tmo + TW'(1);

      if (w_go) begin
        r_pass         <= PW'(1);
        r_pass_swapped <= 1'b0;
        r_swap_count   <= '0;
        r_err          <= 1'b0;
      end else begin
        if (w_new_pass) begin
          r_pass         <= r_pass + PW'(1);
          r_pass_swapped <= 1'b0;
        end
        if (r_state == S_SWAP) begin
          r_pass_swapped <= 1'b1;
          if (r_swap_count != 16'hFFFF) r_swap_count <= r_swap_count + 16'd1;
        end
        if (w_tmo) r_err <= 1'b1;
      end

      if (w_state_nxt == S_ISSUE) begin
        for (int k = 0; k < NSLOT; k++) begin
          r_xs[k*CW +: CW] <= w_win[k].x;
          r_ys[k*CW +: CW] <= w_win[k].y;
        end
      end
    end
  end

  always_comb begin
    o_rd_x = '0;
    o_rd_y = '0;
    if (32'(i_rd_idx) < N) begin
      o_rd_x = r_pts[i_rd_idx].x;
      o_rd_y = r_pts[i_rd_idx].y;
    end
  end

  assign o_busy        = w_busy;
  assign o_done        = (r_state == S_DONE);
  assign o_swap_count  = r_swap_count;
  assign o_err         = r_err;
  assign chk.chk_start = (r_state == S_ISSUE);
  assign chk.chk_xs    = r_xs;
  assign chk.chk_ys    = r_ys;

endmodule

// File: tb/tb_swap_scheduler.sv
// tb/tb_swap_scheduler.sv - self-checking bench for swap_scheduler
module tb_swap_scheduler;

  localparam int N    = 6;
  localparam int CW   = 8;
  localparam int MAXP = 2;
  localparam int TMO  = 4;
  localparam int DLY  = 3;
  localparam int NV   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_en = 1'b0;
  logic [2:0]    ld_idx = '0;
  logic [CW-1:0] ld_x = '0, ld_y = '0;
  logic          start = 1'b0;
  logic [2:0]    rd_idx = '0;
  logic [CW-1:0] rd_x, rd_y;
  logic          busy, done, err;
  logic [15:0]   swap_count;

  always #5 clk = ~clk;

  swap_scheduler_if #(.CW(CW)) chk_if ();

  swap_scheduler #(.N(N), .CW(CW), .MAX_PASSES(MAXP), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ld_en      (ld_en),
    .i_ld_idx     (ld_idx),
    .i_ld_x       (ld_x),
    .i_ld_y       (ld_y),
    .i_start      (start),
    .i_rd_idx     (rd_idx),
    .o_rd_x       (rd_x),
    .o_rd_y       (rd_y),
    .o_busy       (busy),
    .o_done       (done),
    .o_swap_count (swap_count),
    .o_err        (err),
    .chk          (chk_if)
  );

  // policy: 0 never swap, 1 swap only pass 1 pair (1,4), 2 always swap,
  // 3 checker never answers
  typedef struct {
    logic [7:0] x  [N];
    int         policy;
    bit         early;
    bit         poke;
    logic [7:0] ex [N];
    int         esw;
    int         echk;
    bit         eerr;
  } vec_t;

  typedef struct {
    logic [47:0] xs;
    logic [47:0] ys;
    bit          res;
  } exp_t;

  vec_t vt [NV];
  exp_t q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_chk = 0;
  int n_done = 0;
  int last_start = -1;
  int pol = 0;
  bit early = 1'b0;
  bit sb_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit verdict(input int p, input int pass, input int i, input int j);
    case (p)
      1:       return (pass == 1) && (i == 1) && (j == 4);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [47:0] win(input logic [7:0] a [N], input int i, input int j);
    return {a[j+1], a[j], a[j-1], a[i+1], a[i], a[i-1]};
  endfunction

  // Reference walk of the 2-opt passes: pushes one expected window and
  // verdict per check the scheduler must issue.
  task automatic build_model(input int id);
    logic [7:0] mx [N];
    logic [7:0] my [N];
    logic [7:0] t;
    int   pass;
    bit   sw;
    bit   more;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      mx[k] = vt[id].x[k];
      my[k] = vt[id].x[k] + 8'd7;
    end
    pass = 1;
    more = 1'b1;
    while (more) begin
      sw = 1'b0;
      for (int i = 1; i <= N - 4; i++) begin
        for (int j = i + 2; j <= N - 2; j++) begin
          e.xs  = win(mx, i, j);
          e.ys  = win(my, i, j);
          e.res = verdict(vt[id].policy, pass, i, j);
          q.push_back(e);
          if (e.res) begin
            t = mx[i]; mx[i] = mx[j]; mx[j] = t;
            t = my[i]; my[i] = my[j]; my[j] = t;
            sw = 1'b1;
          end
        end
      end
      more = sw && (pass < MAXP);
      if (more) pass++;
    end
  endtask

  // Checker model: compares the issued window with the scoreboard head and
  // answers DLY cycles after the issue pulse.
  initial begin
    exp_t e;
    chk_if.chk_complete = 1'b0;
    chk_if.chk_res      = 1'b0;
    e = '{default: '0};
    forever begin
      @(negedge clk);
      if (chk_if.chk_start === 1'b1 && sb_on) begin
        n_chk++;
        if (pol == 3 && last_start >= 0) chk("tmo_spacing", 64'(cyc - last_start), 64'd6);
        last_start = cyc;
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("win_xs", 64'(chk_if.chk_xs), 64'(e.xs));
          chk("win_ys", 64'(chk_if.chk_ys), 64'(e.ys));
        end
        if (pol != 3) begin
          if (early) begin
            chk_if.chk_complete = 1'b1;
            chk_if.chk_res      = 1'b1;
            @(negedge clk);
            chk_if.chk_complete = 1'b0;
            chk_if.chk_res      = 1'b0;
            repeat (DLY - 1) @(negedge clk);
          end else begin
            repeat (DLY) @(negedge clk);
          end
          chk_if.chk_complete = 1'b1;
          chk_if.chk_res      = e.res;
          @(negedge clk);
          chk_if.chk_complete = 1'b0;
          chk_if.chk_res      = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (t < 3000 && done !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic run_case(input int id);
    build_model(id);
    n_chk = 0;
    n_done = 0;
    last_start = -1;
    pol = vt[id].policy;
    early = vt[id].early;
    sb_on = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k != 2) begin
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 3'(k); ld_x = vt[id].x[k]; ld_y = vt[id].x[k] + 8'd7;
      end
    end
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 3'd2; ld_x = vt[id].x[2]; ld_y = vt[id].x[2] + 8'd7;
    start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    chk($sformatf("c%0d_busy_after_start", id), 64'(busy), 64'd1);
    if (vt[id].poke) begin
      repeat (2) @(negedge clk);
      ld_en = 1'b1; ld_idx = 3'd2; ld_x = 8'd99; ld_y = 8'd99; start = 1'b1;
      @(negedge clk);
      ld_en = 1'b0; start = 1'b0;
    end
    wait_done($sformatf("c%0d_done_seen", id));
    repeat (4) @(negedge clk);
    chk($sformatf("c%0d_done_pulses", id), 64'(n_done), 64'd1);
    chk($sformatf("c%0d_checks", id), 64'(n_chk), 64'(vt[id].echk));
    chk($sformatf("c%0d_sb_left", id), 64'(q.size()), 64'd0);
    chk($sformatf("c%0d_swaps", id), 64'(swap_count), 64'(vt[id].esw));
    chk($sformatf("c%0d_err", id), 64'(err), 64'(vt[id].eerr));
    chk($sformatf("c%0d_busy_end", id), 64'(busy), 64'd0);
    for (int k = 0; k < N; k++) begin
      rd_idx = 3'(k);
      #1;
      chk($sformatf("c%0d_rd_x%0d", id, k), 64'(rd_x), 64'(vt[id].ex[k]));
      chk($sformatf("c%0d_rd_y%0d", id, k), 64'(rd_y), 64'(vt[id].ex[k] + 8'd7));
    end
    q.delete();
    sb_on = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    vt[0].x = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[0].ex = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[0].policy = 0; vt[0].early = 0; vt[0].poke = 0; vt[0].esw = 0; vt[0].echk = 3; vt[0].eerr = 0;
    vt[1].x = '{8'd0, 8'd100, 8'd30, 8'd60, 8'd10, 8'd150};
    vt[1].ex = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[1].policy = 1; vt[1].early = 0; vt[1].poke = 0; vt[1].esw = 1; vt[1].echk = 6; vt[1].eerr = 0;
    vt[2].x = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[2].ex = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[2].policy = 3; vt[2].early = 0; vt[2].poke = 0; vt[2].esw = 0; vt[2].echk = 3; vt[2].eerr = 1;
    vt[3].x = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    vt[3].ex = '{8'd0, 8'd2, 8'd1, 8'd4, 8'd3, 8'd5};
    vt[3].policy = 2; vt[3].early = 0; vt[3].poke = 0; vt[3].esw = 6; vt[3].echk = 6; vt[3].eerr = 0;
    vt[4].x = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[4].ex = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[4].policy = 0; vt[4].early = 1; vt[4].poke = 0; vt[4].esw = 0; vt[4].echk = 3; vt[4].eerr = 0;
    vt[5].x = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[5].ex = '{8'd0, 8'd10, 8'd30, 8'd60, 8'd100, 8'd150};
    vt[5].policy = 0; vt[5].early = 0; vt[5].poke = 1; vt[5].esw = 0; vt[5].echk = 3; vt[5].eerr = 0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_chk_start", 64'(chk_if.chk_start), 64'd0);
    chk("rst_swaps", 64'(swap_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_win_xs", 64'(chk_if.chk_xs), 64'd0);
    chk("rst_rd_x0", 64'(rd_x), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int c = 0; c < NV; c++) run_case(c);

    // Reset in WAIT after one swap has landed: everything must clear at once.
    build_model(3);
    n_chk = 0; last_start = -1; pol = 2; early = 1'b0; sb_on = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 3'(k); ld_x = vt[3].x[k]; ld_y = vt[3].x[k] + 8'd7;
    end
    @(negedge clk);
    ld_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (t < 200 && n_chk < 2) begin
      @(negedge clk);
      t++;
    end
    chk("mr_second_check", 64'(n_chk), 64'd2);
    @(negedge clk);
    chk("mr_swaps_before", 64'(swap_count), 64'd1);
    rst = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_chk_start", 64'(chk_if.chk_start), 64'd0);
    chk("mr_swaps", 64'(swap_count), 64'd0);
    chk("mr_win_xs", 64'(chk_if.chk_xs), 64'd0);
    for (int k = 0; k < N; k++) begin
      rd_idx = 3'(k);
      #1;
      chk($sformatf("mr_rd_x%0d", k), 64'(rd_x), 64'd0);
      chk($sformatf("mr_rd_y%0d", k), 64'(rd_y), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_idle_after", 64'(busy), 64'd0);
    chk("mr_no_done", 64'(done), 64'd0);
    q.delete();
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/swap_scheduler.md
Name: swap_scheduler

Overview:
- Initiator side of the swap-check protocol: holds a path of N points and walks every non-adjacent node pair (i,j).
- For each pair it presents the six-point window (i-1,i,i+1,j-1,j,j+1) to an external swap checker, waits for the verdict, and exchanges nodes i and j in its own storage when the verdict is 1.
- Repeats passes until a pass makes no swap or MAX_PASSES is reached.
- Sits between the host load/readback interface and the checker in the FPGA path solver.

Parameters:
- N, 8, number of path points; minimum 5. Endpoints 0 and N-1 are never moved.
- CW, 8, coordinate width.
- MAX_PASSES, 16, pass limit.
- TIMEOUT, 255, maximum WAIT cycles per check before the scheduler gives up on it.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_en  in  1  write one point; ignored while busy.
- ld_idx  in  $clog2(N)  point index; index >= N is ignored.
- ld_x  in  CW  x coordinate.
- ld_y  in  CW  y coordinate.
- start  in  1  one-cycle request to optimise; ignored while busy.
- rd_idx  in  $clog2(N)  readback index.
- rd_x  out  CW  combinational x of point rd_idx.
- rd_y  out  CW  combinational y of point rd_idx.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at end of run.
- swap_count  out  16  swaps made in this run; saturates at 16'hFFFF.
- err  out  1  sticky per run; set on any check timeout.
- chk_start  out  1  one-cycle pulse issuing a check.
- chk_xs  out  6*CW  window x; slot k at bits [k*CW +: CW], order i-1,i,i+1,j-1,j,j+1.
- chk_ys  out  6*CW  window y, same order.
- chk_res  in  1  1 = swapping i and j is beneficial; valid only with chk_complete.
- chk_complete  in  1  verdict strobe.

Behaviour:
- Reset: all points 0; i=1, j=3; pass counter 0; swap_count 0; err 0; busy, done, chk_start 0; state IDLE. Reset mid-run aborts immediately with no partial swap.
- IDLE: ld_en writes the point in the next cycle. On start: clear swap_count and err, set i=1, j=3, clear pass_swapped, load pass counter=1, go to ISSUE. If start and ld_en are both high, the load is performed first and start is honoured.
- ISSUE: chk_start=1 for exactly one cycle, then WAIT. Clear the timeout counter.
- chk_xs and chk_ys are registered, driven from the point array at current (i,j), and stay stable from ISSUE through the end of WAIT.
- WAIT: chk_complete is sampled only in WAIT, so a verdict in the ISSUE cycle is ignored.
  - chk_complete with chk_res=1 -> SWAP.
  - chk_complete with chk_res=0 -> NEXT.
  - Timeout counter reaching TIMEOUT without chk_complete -> set err, treat as res=0, go to NEXT.
- SWAP: one cycle. Exchange x and y of nodes i and j, increment swap_count (saturating), set pass_swapped, then NEXT.
- NEXT: one cycle.
  - If j < N-2: j++.
  - Otherwise i++ and j=i+2.
  - If the new i > N-4, the pass has ended:
    - pass_swapped and pass counter < MAX_PASSES -> pass counter++, i=1, j=3, clear pass_swapped.
    - Otherwise -> DONE.
  - If the pass continues, go to ISSUE.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Checks per pass: (N-4)(N-3)/2.
- Readback (rd_x, rd_y) is valid at any time, including mid-run.

Decomposition:
- Package solver_pkg holds:
  - typedef point_t {x,y} of CW bits each;
  - state enum {IDLE, ISSUE, WAIT, SWAP, NEXT, DONE};
  - window slot order constants.
- The pair iterator (i, j, end-of-pass flag) is natural as one sub-module, pair_iter.

Test Plan:
- Sorted path: N=6, x=0,10,30,60,100,150, y=0; checker model returns res=0 after 3 cycles -> 3 checks (1,3),(1,4),(2,4); swap_count=0; done once; readback unchanged.
- Single swap: x=0,100,30,60,10,150; model returns res=1 only for pass 1 pair (1,4) -> readback 0,10,30,60,100,150; swap_count=1; 2 passes, 6 chk_start pulses.
- Timeout: TIMEOUT=4; checker never completes -> err=1; 3 checks each lasting 4 WAIT cycles; done; points unchanged.
- Pass limit: MAX_PASSES=2; model always returns res=1 -> exactly 6 checks and 6 swaps, swap_count=6, done after pass 2.
- Ignored inputs: start and ld_en pulsed while busy -> no restart and no point change.
- Reset mid-WAIT: rst low during WAIT -> busy=0, chk_start=0, all points 0, swap_count=0 within the reset cycle.
- Early strobe: chk_complete high in the ISSUE cycle is ignored, and the scheduler still waits for a strobe in WAIT.
